ifu_fetch: RTL and testbench

Instruction fetch unit that sits directly upstream of the decode/execute datapath. It owns the fetch PC and issues word-aligned requests on a valid/ready instruction-memory port. It buffers returned instructions, each tagged with its PC, in a small FIFO and hands them downstream on a valid/ready port. It supports a one-cycle redirect (branch/jump/exception target) that flushes all fetched-but-unconsumed work.

---
 rtl/ifu_fetch.sv | 136 +++++++++++++
 tb/tb_ifu_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
//   Owns the fetch PC and issues word-aligned requests on a valid/ready
//   instruction-memory port. At most one request is outstanding at a time.
//   Returned words are tagged with their PC and buffered in a DEPTH-entry
//   FIFO that feeds decode on a valid/ready port. A redirect flushes the
//   buffer, retargets fetch and drops any in-flight response.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   imem_req_valid/ready/addr fetch request channel (addr word aligned)
//   imem_resp_valid/data      one response per accepted request
//   redirect_valid/pc         one-cycle fetch redirect, highest priority
//   inst_valid/ready          instruction handoff to decode
//   inst, inst_pc             FIFO head word and its PC
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   state_e             state_q;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        req_pc_q;
   logic [31:0]        inst_mem_q [DEPTH];
   logic [31:0]        pc_mem_q   [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               req_fire_c;
   logic               push_c;
   logic               pop_c;
   logic               unused_c;

   // Redirect targets are forced word aligned; the low bits are ignored.
   assign unused_c = ^redirect_pc[1:0];

   assign imem_req_valid = (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign inst_valid     = (count_q != '0) && !redirect_valid;
   assign inst           = inst_mem_q[rd_ptr_q];
   assign inst_pc        = pc_mem_q[rd_ptr_q];

   assign req_fire_c = imem_req_valid && imem_req_ready;
   // A response arriving with a redirect is discarded, so never pushed.
   assign push_c     = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
   assign pop_c      = inst_valid && inst_ready;

   // Next-state for fetch PC and FIFO bookkeeping; redirect wins outright.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (req_fire_c) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push_c)     wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         if (pop_c)      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Request FSM: a response in WAIT/DROP always returns to IDLE; a
   // redirect while waiting turns the pending response into a drop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (req_fire_c) state_q <= ST_WAIT;
            ST_WAIT: begin
               if (imem_resp_valid)     state_q <= ST_IDLE;
               else if (redirect_valid) state_q <= ST_DROP;
            end
            ST_DROP: if (imem_resp_valid) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Datapath registers and FIFO storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (req_fire_c) req_pc_q <= fetch_pc_q;
         if (push_c) begin
            inst_mem_q[wr_ptr_q] <= imem_resp_data;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch (DEPTH=2). A small memory
// responder inside tick() answers each accepted request after lat cycles
// with data_of(addr); each test task checks outputs against hand-derived
// cycle-by-cycle expectations.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int errors = 0;
   int checks = 0;

   // responder state
   int          lat = 1;
   bit          pend = 1'b0;
   int          rem = 0;
   logic [31:0] paddr = '0;

   ifu_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Advance one cycle; returns at posedge+1 with the responder updated.
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      #2;
      hs = rst && imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (hs) begin
         pend  = 1'b1;
         rem   = lat;
         paddr = a;
      end
      if (pend) begin
         rem = rem - 1;
         if (rem == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = data_of(paddr);
            pend            = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pend = 1'b0;
      imem_resp_valid = 1'b0;
      redirect_valid = 1'b0;
      inst_ready = 1'b1;
      lat = 1;
      tick();
      tick();
      rst = 1'b1;
      #1;
   endtask

   task automatic chk_req(input string nm, input logic v, input logic [31:0] a);
      // request-side observation used by several scenarios
      checks++;
      if (imem_req_valid !== v || (v && imem_req_addr !== a)) begin
         errors++;
         $display("FAIL %s: req_valid=%0b addr=%h, expected valid=%0b addr=%h",
                  nm, imem_req_valid, imem_req_addr, v, a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid);
      end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         errors++;
         $display("FAIL reset_req: valid=%0b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RST_PC);
      end
   endtask

   task automatic test_basic();
      logic [31:0] pc;
      do_reset();
      chk_req("basic_first_req", 1'b1, RST_PC);
      tick();
      for (int i = 0; i < 3; i++) begin
         pc = RST_PC + 32'(4 * i);
         checks++;
         if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL basic_gap%0d: inst_valid=%0b want 0", i, inst_valid);
         end
         tick();
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== pc || inst !== data_of(pc)) begin
            errors++;
            $display("FAIL basic_inst%0d: valid=%0b pc=%h inst=%h want 1 %h %h",
                     i, inst_valid, inst_pc, inst, pc, data_of(pc));
         end
         chk_req("basic_next_req", 1'b1, pc + 32'd4);
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      inst_ready = 1'b0;
      tick(); tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
         errors++; $display("FAIL stall_first: valid=%0b pc=%h want 1 %h", inst_valid, inst_pc, RST_PC);
      end
      tick(); tick();
      chk_req("stall_full_blocks", 1'b0, '0);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
         errors++; $display("FAIL stall_head: valid=%0b pc=%h want 1 %h", inst_valid, inst_pc, RST_PC);
      end
      tick();
      chk_req("stall_still_blocked", 1'b0, '0);
      inst_ready = 1'b1;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RST_PC + 32'd4) begin
         errors++; $display("FAIL stall_drain2: valid=%0b pc=%h want 1 %h", inst_valid, inst_pc, RST_PC + 32'd4);
      end
      chk_req("stall_resume", 1'b1, RST_PC + 32'd8);
      tick();
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL stall_empty: inst_valid=%0b want 0", inst_valid);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      lat = 3;
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_1002;
      #1;
      chk_req("rdw_no_req_on_redirect", 1'b0, '0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk_req("rdw_drop_blocks", 1'b0, '0);
      tick();
      chk_req("rdw_drop_resp_cycle", 1'b0, '0);
      lat = 1;
      tick();
      chk_req("rdw_new_req", 1'b1, 32'h8000_1000);
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL rdw_old_dropped: inst_valid=%0b pc=%h want 0", inst_valid, inst_pc);
      end
      tick();
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_1000 || inst !== data_of(32'h8000_1000)) begin
         errors++;
         $display("FAIL rdw_first_inst: valid=%0b pc=%h inst=%h want 1 80001000 %h",
                  inst_valid, inst_pc, inst, data_of(32'h8000_1000));
      end
   endtask

   task automatic test_redirect_collide();
      do_reset();
      inst_ready = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (inst_valid !== 1'b1 || imem_resp_valid !== 1'b1) begin
         errors++; $display("FAIL rdc_setup: inst_valid=%0b resp=%0b want 1 1", inst_valid, imem_resp_valid);
      end
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_2000;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL rdc_inst_valid_masked: got %0b want 0", inst_valid);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL rdc_flushed: inst_valid=%0b pc=%h want 0", inst_valid, inst_pc);
      end
      chk_req("rdc_new_req", 1'b1, 32'h8000_2000);
      tick(); tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_2000) begin
         errors++; $display("FAIL rdc_first_inst: valid=%0b pc=%h want 1 80002000", inst_valid, inst_pc);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk_req("wrap_aligned_req", 1'b1, 32'hFFFF_FFFC);
      tick(); tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_inst: valid=%0b pc=%h want 1 fffffffc", inst_valid, inst_pc);
      end
      chk_req("wrap_next_req", 1'b1, 32'h0000_0000);
   endtask

   task automatic test_reset_mid();
      do_reset();
      inst_ready = 1'b0;
      tick(); tick();
      lat = 3;
      tick(); tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RST_PC || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_setup: inst_valid=%0b pc=%h req_valid=%0b want 1 %h 0",
                  inst_valid, inst_pc, imem_req_valid, RST_PC);
      end
      rst = 1'b0;
      pend = 1'b0;
      imem_resp_valid = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL rmid_inst_valid: got %0b want 0", inst_valid);
      end
      chk_req("rmid_req_during_reset", 1'b1, RST_PC);
      tick();
      rst = 1'b1;
      lat = 1;
      inst_ready = 1'b1;
      #1;
      chk_req("rmid_restart_req", 1'b1, RST_PC);
      tick(); tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== data_of(RST_PC)) begin
         errors++;
         $display("FAIL rmid_first_inst: valid=%0b pc=%h inst=%h want 1 %h %h",
                  inst_valid, inst_pc, inst, RST_PC, data_of(RST_PC));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_redirect_collide();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
